// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core data-memory bus.
//   Store-byte writes to TXDATA are queued in a FIFO.
//   A small FSM serialises the queued bytes LSB first on TXD.
//   The bit time is DIV+1 clock cycles.
//   Software polls STATUS with ordinary loads.
//
//   Register map (word offset = ADDR[3:2]):
//     00 TXDATA  W: WSTB[0] pushes DATAI[7:0]           R: 0
//     01 STATUS  R: [0] full [1] empty [2] busy [3] ovf [4] ie [15:8] count
//                W: WSTB[0] & DATAI[3] clears ovf; WSTB[0] writes ie
//     10 DIV     R/W: [15:0], byte lanes WSTB[1:0]
//     11 reserved, reads 0
//
//   Optional feature macro: MMIO_UART_IRQ_EN
//     Defined:   the IRQ port and the IE bit (STATUS[4]) exist.
//     Undefined: there is no IRQ port and STATUS[4] reads 0.
//
//   Ports:
//     CLK    in   clock, rising edge
//     RSTN   in   asynchronous active-low reset
//     CE     in   access strobe (already address-decoded)
//     ADDR   in   word address [31:2]; only [3:2] is decoded
//     DATAI  in   write data
//     WSTB   in   byte write strobes; 0 with CE=1 is a read
//     DATAO  out  read data (combinational), 0 when CE=0
//     TXD    out  registered serial output, idle high
//     IRQ    out  registered interrupt (MMIO_UART_IRQ_EN only)
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] BAUD_DIV   = 16'd867
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        CE,
   input  logic [31:2] ADDR,
   input  logic [31:0] DATAI,
   input  logic [3:0]  WSTB,
   output logic [31:0] DATAO,
   output logic        TXD
`ifdef MMIO_UART_IRQ_EN
   ,
   output logic        IRQ
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   div_l_q, div_l_d;
   logic [15:0]   cyc_q, cyc_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

`ifdef MMIO_UART_IRQ_EN
   logic          ie_q, ie_d;
   logic          irq_q, irq_d;
`endif

   logic        sel_tx, sel_st, sel_div;
   logic        full, empty, busy;
   logic        push_req, push, pop;
   logic [15:0] status;
   logic        unused_bits;

   // Address decode and FIFO handshake
   assign sel_tx   = CE && (ADDR[3:2] == 2'b00);
   assign sel_st   = CE && (ADDR[3:2] == 2'b01);
   assign sel_div  = CE && (ADDR[3:2] == 2'b10);

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign busy     = (state_q != S_IDLE);

   assign push_req = sel_tx && WSTB[0];
   // A push to a full FIFO is dropped even if a pop frees a slot this cycle.
   assign push     = push_req && !full;
   assign pop      = (state_q == S_IDLE) && !empty;

   assign unused_bits = ^{ADDR[31:4], DATAI[31:16], WSTB[3:2]};

   // Register-file and FIFO bookkeeping
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      div_d    = div_q;
`ifdef MMIO_UART_IRQ_EN
      ie_d     = ie_q;
`endif
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      if (push_req && full)                    ovf_d = 1'b1;
      else if (sel_st && WSTB[0] && DATAI[3])  ovf_d = 1'b0;

`ifdef MMIO_UART_IRQ_EN
      if (sel_st && WSTB[0]) ie_d = DATAI[4];
`endif
      if (sel_div && WSTB[0]) div_d[7:0]  = DATAI[7:0];
      if (sel_div && WSTB[1]) div_d[15:8] = DATAI[15:8];
   end

   // Transmit FSM: next state and next TXD.
   // TXD is registered from the current state, so it trails the state by one
   // cycle; every level still lasts exactly DIV_L+1 cycles.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      div_l_d = div_l_q;
      txd_d   = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               shift_d = mem_q[rd_ptr_q];
               div_l_d = div_q;         // divider frozen for the whole frame
               cyc_d   = '0;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            txd_d = 1'b0;
            if (cyc_q == div_l_q) begin
               cyc_d   = '0;
               state_d = S_DATA;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         S_DATA: begin
            txd_d = shift_q[0];
            if (cyc_q == div_l_q) begin
               cyc_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         S_STOP: begin
            if (cyc_q == div_l_q) begin
               cyc_d   = '0;
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MMIO_UART_IRQ_EN
   assign irq_d = ie_q && ((empty && !busy) || ovf_q);
`endif

   // Control state
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= BAUD_DIV;
         cyc_q    <= '0;
         bit_q    <= '0;
         txd_q    <= 1'b1;
`ifdef MMIO_UART_IRQ_EN
         ie_q     <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         txd_q    <= txd_d;
`ifdef MMIO_UART_IRQ_EN
         ie_q     <= ie_d;
         irq_q    <= irq_d;
`endif
      end
   end

   // Datapath storage.
   // These registers are always written before they are read, so they need no reset.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= DATAI[7:0];
      shift_q <= shift_d;
      div_l_q <= div_l_d;
   end

   // Read mux
   always_comb begin
      status        = '0;
      status[0]     = full;
      status[1]     = empty;
      status[2]     = busy;
      status[3]     = ovf_q;
`ifdef MMIO_UART_IRQ_EN
      status[4]     = ie_q;
`endif
      status[15:8]  = 8'(count_q);
   end

   always_comb begin
      DATAO = '0;
      if (CE) begin
         unique case (ADDR[3:2])
            2'b01:   DATAO = {16'd0, status};
            2'b10:   DATAO = {16'd0, div_q};
            default: DATAO = '0;
         endcase
      end
   end

   assign TXD = txd_q;
`ifdef MMIO_UART_IRQ_EN
   assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

   localparam int          DEPTH   = 16;
   localparam logic [15:0] RST_DIV = 16'd867;
   localparam int          RX_TMO  = 5000;

   logic        CLK  = 1'b0;
   logic        RSTN = 1'b1;
   logic        CE   = 1'b0;
   logic [31:2] ADDR = '0;
   logic [31:0] DATAI = '0;
   logic [3:0]  WSTB = '0;
   logic [31:0] DATAO;
   logic        TXD;
`ifdef MMIO_UART_IRQ_EN
   logic        IRQ;
`endif

   int checks   = 0;
   int failures = 0;

   mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .BAUD_DIV(RST_DIV)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .CE    (CE),
      .ADDR  (ADDR),
      .DATAI (DATAI),
      .WSTB  (WSTB),
      .DATAO (DATAO),
      .TXD   (TXD)
`ifdef MMIO_UART_IRQ_EN
      , .IRQ (IRQ)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          wr;
      logic [1:0]  off;
      logic [31:0] data;
      logic [3:0]  wstb;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
      @(negedge CLK);
      CE = 1'b1; ADDR = {28'($urandom), off}; DATAI = d; WSTB = s;
      @(posedge CLK);
      #1;
      CE = 1'b0; WSTB = '0; DATAI = '0;
   endtask

   task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
      @(negedge CLK);
      CE = 1'b1; ADDR = {28'($urandom), off}; WSTB = '0; DATAI = $urandom;
      #1;
      d = DATAO;
      CE = 1'b0;
   endtask

   // Behavioural 8N1 receiver.
   // It is called at a sample point (#1 after a rising edge) and checks that
   // every bit holds its level for exactly div+1 samples.
   // 'gap' is the number of idle-high samples seen before the start bit.
   task automatic rx_byte(input int div, output logic [7:0] b, output bit ok, output int gap);
      ok  = 1'b1;
      b   = '0;
      gap = 0;
      while (TXD !== 1'b0 && gap < RX_TMO) begin
         @(posedge CLK); #1; gap++;
      end
      if (TXD !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int c = 0; c <= div; c++) begin
         if (TXD !== 1'b0) ok = 1'b0;
         @(posedge CLK); #1;
      end
      for (int i = 0; i < 8; i++) begin
         b[i] = TXD;
         for (int c = 0; c <= div; c++) begin
            if (TXD !== b[i]) ok = 1'b0;
            @(posedge CLK); #1;
         end
      end
      for (int c = 0; c <= div; c++) begin
         if (TXD !== 1'b1) ok = 1'b0;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [9:0]  fr;
      logic [3:0]  w;
      logic [7:0]  b0, b1;
      bit          ok0, ok1;
      int          g0, g1, bad;
      logic [7:0]  expq[$];

      // Reset
      #1 RSTN = 1'b0;
      repeat (3) @(posedge CLK);
      #1 check("reset_txd", {31'd0, TXD}, 32'd1);
      @(negedge CLK) RSTN = 1'b1;

      // Register-access table
      vt[0]  = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h0000_0002};
      vt[1]  = '{1'b0, 2'd2, 32'h0,        4'h0, {16'd0, RST_DIV}};
      vt[2]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h0};
      vt[3]  = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0};
      vt[4]  = '{1'b1, 2'd2, 32'h0000_1234, 4'h3, 32'h0};
      vt[5]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0000_1234};
      vt[6]  = '{1'b1, 2'd2, 32'hFFFF_AB00, 4'h2, 32'h0};
      vt[7]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0000_AB34};
      vt[8]  = '{1'b1, 2'd2, 32'hFFFF_FF77, 4'hD, 32'h0};
      vt[9]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0000_AB77};
      vt[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'h0};
      vt[11] = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0};
      vt[12] = '{1'b1, 2'd0, 32'h0000_00AB, 4'hE, 32'h0};
      vt[13] = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h0000_0002};
      vt[14] = '{1'b1, 2'd1, 32'hFFFF_FFEF, 4'h1, 32'h0};
      vt[15] = '{1'b0, 2'd1, 32'h0,        4'h0, 32'h0000_0002};
      vt[16] = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0000_AB77};
      for (int i = 0; i < 17; i++) begin
         if (vt[i].wr) bus_write(vt[i].off, vt[i].data, vt[i].wstb);
         else begin
            bus_read(vt[i].off, rd);
            check($sformatf("vec%0d", i), rd, vt[i].exp);
         end
      end
      @(negedge CLK);
      CE = 1'b0; ADDR = 30'd2;
      #1 check("ce_low_datao", DATAO, 32'h0);

      // One 0x55 frame at DIV=3, with exact timing
      bus_write(2'd2, 32'd3, 4'h3);
      bus_write(2'd0, 32'h55, 4'h1);
      check("t1_txd_n0", {31'd0, TXD}, 32'd1);
      @(posedge CLK); #1;
      check("t1_txd_n1", {31'd0, TXD}, 32'd1);
      @(posedge CLK); #1;
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 4; c++) begin
            w[c] = TXD;
            @(posedge CLK); #1;
         end
         check($sformatf("t1_bit%0d", i), {28'd0, w}, fr[i] ? 32'hF : 32'h0);
      end
      bus_read(2'd1, rd);
      check("t1_status_idle", rd, 32'h0000_0002);

      // Overflow: hold TX busy in a slow frame, then queue 17 bytes at DIV=0
      bus_write(2'd2, 32'd200, 4'h3);
      fork
         begin
            @(posedge CLK); #1;
            rx_byte(200, b0, ok0, g0);
            check("t2_dummy_ok", {31'd0, ok0}, 32'd1);
            check("t2_dummy_byte", {24'd0, b0}, 32'hAA);
            for (int i = 0; i < 16; i++) begin
               rx_byte(0, b1, ok1, g1);
               check($sformatf("t2_ok%0d", i), {31'd0, ok1}, 32'd1);
               check($sformatf("t2_byte%0d", i), {24'd0, b1}, i);
               check($sformatf("t2_gap%0d", i), g1, 32'd1);
            end
         end
         begin
            bus_write(2'd0, 32'hAA, 4'h1);
            bus_write(2'd2, 32'd0, 4'h3);
            for (int j = 0; j < 17; j++) bus_write(2'd0, j, 4'h1);
            bus_read(2'd1, rd);
            check("t2_status_full", rd, 32'h0000_100D);
         end
      join
      bad = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (TXD !== 1'b1) bad++;
      end
      check("t2_no_extra_frame", bad, 32'd0);
      bus_read(2'd1, rd);
      check("t2_status_ovf", rd, 32'h0000_000A);

      // OVF clear
      bus_write(2'd1, 32'h8, 4'h1);
      bus_read(2'd1, rd);
      check("t3_status_clr", rd, 32'h0000_0002);

      // DIV change mid-frame applies to the next frame only
      bus_write(2'd2, 32'd5, 4'h3);
      fork
         begin
            @(posedge CLK); #1;
            rx_byte(5, b0, ok0, g0);
            check("t4_ok0", {31'd0, ok0}, 32'd1);
            check("t4_byte0", {24'd0, b0}, 32'hC3);
            rx_byte(2, b1, ok1, g1);
            check("t4_ok1", {31'd0, ok1}, 32'd1);
            check("t4_byte1", {24'd0, b1}, 32'h3C);
         end
         begin
            bus_write(2'd0, 32'hC3, 4'h1);
            repeat (10) @(posedge CLK);
            bus_write(2'd2, 32'd2, 4'h3);
            bus_write(2'd0, 32'h3C, 4'h1);
         end
      join

`ifdef MMIO_UART_IRQ_EN
      // IRQ: low while busy, high one cycle after the return to IDLE
      bus_write(2'd1, 32'h10, 4'h1);
      bus_write(2'd2, 32'd1, 4'h3);
      check("t6_irq_idle", {31'd0, IRQ}, 32'd1);
      bus_read(2'd1, rd);
      check("t6_status_ie", rd, 32'h0000_0012);
      bus_write(2'd0, 32'hA5, 4'h1);
      bad = 0;
      for (int k = 1; k <= 21; k++) begin
         @(posedge CLK); #1;
         if (IRQ !== 1'b0) bad++;
      end
      check("t6_irq_busy_low", bad, 32'd0);
      @(posedge CLK); #1;
      check("t6_irq_rise", {31'd0, IRQ}, 32'd1);
      bus_write(2'd1, 32'h0, 4'h1);
`endif

      // Randomised frames against a queue model of the FIFO
      for (int r = 0; r < 4; r++) begin
         int div, n;
         div = $urandom_range(0, 3);
         n   = $urandom_range(1, 10);
         expq.delete();
         for (int i = 0; i < n; i++) expq.push_back(8'($urandom));
         bus_write(2'd2, div, 4'h3);
         fork
            begin
               @(posedge CLK); #1;
               for (int i = 0; i < n; i++) begin
                  rx_byte(div, b0, ok0, g0);
                  check($sformatf("rnd%0d_ok%0d", r, i), {31'd0, ok0}, 32'd1);
                  check($sformatf("rnd%0d_byte%0d", r, i), {24'd0, b0}, {24'd0, expq[i]});
               end
            end
            begin
               for (int j = 0; j < n; j++) begin
                  repeat ($urandom_range(0, 3)) @(posedge CLK);
                  bus_write(2'd0, {24'($urandom), expq[j]}, 4'($urandom) | 4'h1);
               end
            end
         join
         bus_read(2'd1, rd);
         check($sformatf("rnd%0d_status", r), rd, 32'h0000_0002);
      end

      // Reset mid-frame: TXD returns high immediately and queued data is lost
      bus_write(2'd2, 32'd9, 4'h3);
      bus_write(2'd0, 32'h00, 4'h1);
      bus_write(2'd0, 32'h77, 4'h1);
      bus_write(2'd0, 32'h99, 4'h1);
      repeat (25) @(posedge CLK);
      #2;
      check("t5_txd_data_low", {31'd0, TXD}, 32'd0);
      RSTN = 1'b0;
      #1;
      check("t5_txd_async", {31'd0, TXD}, 32'd1);
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      bus_read(2'd1, rd);
      check("t5_status", rd, 32'h0000_0002);
      bus_read(2'd2, rd);
      check("t5_div", rd, {16'd0, RST_DIV});
      bad = 0;
      repeat (30) begin
         @(posedge CLK); #1;
         if (TXD !== 1'b1) bad++;
      end
      check("t5_no_tx_after_reset", bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
